winner_bar: RTL and testbench



---
 rtl/arbiter_game_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 48 ++++
 rtl/winner_bar.sv | 166 ++++++++++++++++
 tb/tb_winner_bar.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arbiter_game_pkg.sv
// Shared definitions for the arbiter game blocks.
//   state_e  : round controller states (IDLE / RUN / DONE)
//   WIN_*    : 2-bit encoded round result driven on winner outputs
package arbiter_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running game tick generator.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   clear_in : restarts the count; the next tick follows PRESCALER_COUNT
//              clocks after the clearing edge
//   tick_out : registered single-clock pulse, one every PRESCALER_COUNT clocks
module tick_prescaler #(
  parameter int PRESCALER_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CNT_W = $clog2(PRESCALER_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALER_COUNT - 1);
  // Tick is raised one count early so that logic consuming it acts on the
  // edge exactly PRESCALER_COUNT clocks after the clear.
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(PRESCALER_COUNT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (clear_in) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == CNT_MAX) cnt_d = '0;
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/winner_bar.sv
// Round controller and N-LED tug-of-war bar.
//   clk        : system clock
//   reset      : asynchronous active-high reset, returns to IDLE, outputs 0
//   start_in   : level, starts a round when high in IDLE or DONE
//   w1_in      : player 1 pulling (position toward MSB), sampled on ticks
//   w2_in      : player 2 pulling (position toward LSB), sampled on ticks
//   leds_out   : one-hot position, blank in IDLE, blinking in DONE
//   w_done_out : round finished
//   winner_out : 00 none, 01 player 1, 10 player 2, 11 draw
module winner_bar
  import arbiter_game_pkg::*;
#(
  parameter int CLOCK_FREQ      = 12000000,
  parameter int PRESCALER_COUNT = CLOCK_FREQ / 4,
  parameter int N_LEDS          = 5,
  parameter int START_POS       = (N_LEDS - 1) / 2,
  parameter int TIMEOUT_TICKS   = 15,
  parameter int WRAP            = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic              w1_in,
  input  logic              w2_in,
  output logic [N_LEDS-1:0] leds_out,
  output logic              w_done_out,
  output logic [1:0]        winner_out
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic             WRAP_EN   = (WRAP != 0);

  // Position after one tick of pulling: wraps at the ends in WRAP mode,
  // otherwise saturates so pos never leaves [0, N_LEDS-1].
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                input logic up,
                                                input logic dn);
    logic [POS_W-1:0] r;
    r = p;
    if (up && !dn) begin
      if (p == POS_LAST) r = WRAP_EN ? '0 : POS_LAST;
      else               r = p + POS_W'(1);
    end else if (dn && !up) begin
      if (p == '0) r = WRAP_EN ? POS_LAST : '0;
      else         r = p - POS_W'(1);
    end
    return r;
  endfunction

  function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
    logic [N_LEDS-1:0] r;
    r = {{(N_LEDS-1){1'b0}}, 1'b1} << p;
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d, pos_nxt;
  logic [TO_W-1:0]   tout_q, tout_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              done_q, done_d;
  logic [1:0]        win_q, win_d;
  logic              blink_q, blink_d;
  logic              tick;
  logic              start_acc;

  assign start_acc = start_in && (state_q != ST_RUN);
  assign pos_nxt   = step_pos(pos_q, w1_in, w2_in);

  tick_prescaler #(
    .PRESCALER_COUNT(PRESCALER_COUNT)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear_in (start_acc),
    .tick_out (tick)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tout_d  = tout_q;
    leds_d  = leds_q;
    done_d  = done_q;
    win_d   = win_q;
    blink_d = blink_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_d = ST_RUN;
          pos_d   = POS_START;
          tout_d  = '0;
          leds_d  = onehot(POS_START);
          done_d  = 1'b0;
          win_d   = WIN_NONE;
          blink_d = 1'b0;
        end else if (state_q == ST_DONE && tick) begin
          // Blank phase comes first after entering DONE.
          leds_d  = blink_q ? onehot(pos_q) : '0;
          blink_d = !blink_q;
        end
      end

      ST_RUN: begin
        if (tick) begin
          pos_d  = pos_nxt;
          leds_d = onehot(pos_nxt);
          tout_d = tout_q + TO_W'(1);
          // Edge win is checked before timeout so it takes precedence.
          if (!WRAP_EN && pos_nxt == POS_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            win_d   = WIN_P1;
            blink_d = 1'b0;
          end else if (!WRAP_EN && pos_nxt == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            win_d   = WIN_P2;
            blink_d = 1'b0;
          end else if (tout_q == TO_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            blink_d = 1'b0;
            if (pos_nxt > POS_START)      win_d = WIN_P1;
            else if (pos_nxt < POS_START) win_d = WIN_P2;
            else                          win_d = WIN_DRAW;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pos_q   <= POS_START;
      tout_q  <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
      win_q   <= WIN_NONE;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tout_q  <= tout_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
      win_q   <= win_d;
      blink_q <= blink_d;
    end
  end

  assign leds_out   = leds_q;
  assign w_done_out = done_q;
  assign winner_out = win_q;

endmodule

// File: tb/tb_winner_bar.sv
// Directed bench for winner_bar: one saturating instance and one wrapping
// instance sharing clock, reset and player inputs.
module tb_winner_bar;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       w1;
  logic       w2;
  logic [4:0] leds_a, leds_b;
  logic       done_a, done_b;
  logic [1:0] win_a, win_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  winner_bar #(
    .CLOCK_FREQ(16), .PRESCALER_COUNT(4), .N_LEDS(5), .START_POS(2),
    .TIMEOUT_TICKS(6), .WRAP(0)
  ) u_sat (
    .clk(clk), .reset(reset), .start_in(start), .w1_in(w1), .w2_in(w2),
    .leds_out(leds_a), .w_done_out(done_a), .winner_out(win_a)
  );

  winner_bar #(
    .CLOCK_FREQ(16), .PRESCALER_COUNT(4), .N_LEDS(5), .START_POS(2),
    .TIMEOUT_TICKS(6), .WRAP(1)
  ) u_wrap (
    .clk(clk), .reset(reset), .start_in(start), .w1_in(w1), .w2_in(w2),
    .leds_out(leds_b), .w_done_out(done_b), .winner_out(win_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_round();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Inputs are held for one full tick period; returns just after the tick edge.
  task automatic run_tick(input logic a, input logic b);
    w1 = a;
    w2 = b;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; start = 1'b0; w1 = 1'b0; w2 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_leds_a", 32'(leds_a), 'b00000);
    check_val("rst_done_a", 32'(done_a), 0);
    check_val("rst_win_a",  32'(win_a),  0);
    check_val("rst_leds_b", 32'(leds_b), 'b00000);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_val("idle_leds_a", 32'(leds_a), 'b00000);

    // Saturating: player 1 reaches the MSB edge on the second tick
    start_round();
    check_val("st_leds",  32'(leds_a), 'b00100);
    check_val("st_done",  32'(done_a), 0);
    check_val("st_win",   32'(win_a),  0);
    w1 = 1'b1;
    repeat (3) @(negedge clk);
    check_val("pre_tick_leds", 32'(leds_a), 'b00100);
    @(negedge clk);
    check_val("t1_leds", 32'(leds_a), 'b01000);
    check_val("t1_done", 32'(done_a), 0);
    run_tick(1'b1, 1'b0);
    check_val("p1_leds", 32'(leds_a), 'b10000);
    check_val("p1_done", 32'(done_a), 1);
    check_val("p1_win",  32'(win_a),  1);
    run_tick(1'b0, 1'b0);
    check_val("blink0_leds", 32'(leds_a), 'b00000);
    check_val("blink0_win",  32'(win_a),  1);
    run_tick(1'b0, 1'b0);
    check_val("blink1_leds", 32'(leds_a), 'b10000);
    check_val("blink1_done", 32'(done_a), 1);
    start_round();
    check_val("restart_leds", 32'(leds_a), 'b00100);
    check_val("restart_done", 32'(done_a), 0);
    check_val("restart_win",  32'(win_a),  0);

    // Saturating: net-zero pulling times out as a draw
    do_reset();
    start_round();
    run_tick(1'b1, 1'b0);
    run_tick(1'b0, 1'b1);
    run_tick(1'b1, 1'b1);
    run_tick(1'b1, 1'b0);
    run_tick(1'b0, 1'b1);
    check_val("draw_t5_done", 32'(done_a), 0);
    check_val("draw_t5_leds", 32'(leds_a), 'b00100);
    run_tick(1'b0, 1'b0);
    check_val("draw_done", 32'(done_a), 1);
    check_val("draw_win",  32'(win_a),  3);
    check_val("draw_leds", 32'(leds_a), 'b00100);

    // Wrapping: player 2 rotates past the LSB, timeout decides player 1
    do_reset();
    start_round();
    run_tick(1'b0, 1'b1);
    check_val("wr_t1_leds", 32'(leds_b), 'b00010);
    run_tick(1'b0, 1'b1);
    check_val("wr_t2_leds", 32'(leds_b), 'b00001);
    run_tick(1'b0, 1'b1);
    check_val("wr_t3_leds", 32'(leds_b), 'b10000);
    check_val("wr_t3_done", 32'(done_b), 0);
    run_tick(1'b0, 1'b0);
    run_tick(1'b0, 1'b0);
    check_val("wr_t5_done", 32'(done_b), 0);
    run_tick(1'b0, 1'b0);
    check_val("wr_to_done", 32'(done_b), 1);
    check_val("wr_to_win",  32'(win_b),  1);
    check_val("wr_to_leds", 32'(leds_b), 'b10000);

    // Saturating: LSB edge reached on the timeout tick, edge win wins
    do_reset();
    start_round();
    repeat (4) run_tick(1'b0, 1'b0);
    run_tick(1'b0, 1'b1);
    check_val("edge_t5_leds", 32'(leds_a), 'b00010);
    check_val("edge_t5_done", 32'(done_a), 0);
    run_tick(1'b0, 1'b1);
    check_val("edge_leds", 32'(leds_a), 'b00001);
    check_val("edge_done", 32'(done_a), 1);
    check_val("edge_win",  32'(win_a),  2);

    // Asynchronous reset in the middle of a round
    do_reset();
    start_round();
    run_tick(1'b1, 1'b0);
    check_val("mid_leds", 32'(leds_a), 'b01000);
    w1 = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("arst_leds_a", 32'(leds_a), 'b00000);
    check_val("arst_done_a", 32'(done_a), 0);
    check_val("arst_win_a",  32'(win_a),  0);
    check_val("arst_leds_b", 32'(leds_b), 'b00000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_round();
    check_val("post_rst_leds", 32'(leds_a), 'b00100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
